// File: rtl/mips_bus_mem_slave.sv
// rtl/mips_bus_mem_slave.sv - Avalon-MM word memory slave with wait states, stall LFSR, error flag and transfer counter
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous active-low reset
//   read        in   1   read request, held until accepted
//   write       in   1   write request, held until accepted
//   address     in  32   byte address, bits [1:0] ignored
//   byteenable  in   4   write lane enables
//   writedata   in  32   write data
//   waitrequest out  1   request not accepted this cycle
//   readdata    out 32   memory word while read && !waitrequest and in-window, else 0
//   err         out  1   sticky: out-of-window access or read && write seen
//   xfer_count  out 16   completed transfers, wrapping
module mips_bus_mem_slave #(
    parameter string       INIT_FILE   = "",
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 0,
    parameter int          STALL_MODE  = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    output logic [15:0] xfer_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        err_q, err_d;
    logic [15:0] xfer_q, xfer_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          active;
    logic          complete;
    logic          mem_we;
    logic          in_window;
    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic [4:0]    w_eff;
    logic          unused_off_bits;

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
    end

    assign active          = read | write;
    assign off             = address - BASE_ADDR;
    // BASE_ADDR is aligned to the window size, so in-window means no offset bits above the index
    assign in_window       = (off[31:AW+2] == '0);
    assign widx            = off[AW+1:2];
    assign unused_off_bits = ^off[1:0];
    assign w_eff           = 5'(WAIT_CYCLES) + ((STALL_MODE != 0) ? {3'b000, lfsr_q[1:0]} : 5'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        xfer_d      = xfer_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        waitrequest = 1'b0;
        complete    = 1'b0;

        if (!reset) begin
            // nothing may complete while reset is held
            waitrequest = active;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (active) begin
                        if (w_eff != 5'd0) begin
                            waitrequest = 1'b1;
                            cnt_d       = w_eff - 5'd1;
                            state_d     = S_WAIT;
                        end else begin
                            complete = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 5'd0) begin
                        waitrequest = 1'b1;
                        cnt_d       = cnt_q - 5'd1;
                    end else begin
                        complete = active;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (complete) begin
            xfer_d = xfer_q + 16'd1;
            if (!in_window || (read && write)) err_d = 1'b1;
        end
        // a simultaneous read wins; the write half is discarded
        mem_we = complete && write && !read && in_window;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            err_q   <= 1'b0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
            xfer_q  <= xfer_d;
        end
    end

    // memory has no reset: contents survive reset
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) mem_q[widx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    assign readdata   = (read && !waitrequest && in_window) ? mem_q[widx] : 32'h0;
    assign err        = err_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_mips_bus_mem_slave.sv
// tb/tb_mips_bus_mem_slave.sv - scoreboard bench for mips_bus_mem_slave over three wait configurations
module tb_mips_bus_mem_slave;

    localparam int          N     = 3;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam logic [31:0] OOW   = BASE + 32'(DEPTH * 4);
    localparam logic [7:0]  SEED  = 8'hA5;
    // instance 0: W=0 + stall, instance 1: W=3, instance 2: W=5
    localparam logic [11:0] WC    = {4'd5, 4'd3, 4'd0};
    localparam logic [2:0]  SM    = 3'b001;

    typedef struct {
        int          inst;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_v, rd_v, wr_v, wreq_v, err_v;
    logic [31:0]  address, writedata;
    logic [3:0]   byteenable;
    logic [31:0]  rdata_v [N];
    logic [15:0]  xfer_v  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mips_bus_mem_slave #(
            .INIT_FILE   (""),
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES (int'(WC[g*4 +: 4])),
            .STALL_MODE  (int'(SM[g])),
            .LFSR_SEED   (SEED)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_v[g]),
            .read        (rd_v[g]),
            .write       (wr_v[g]),
            .address     (address),
            .byteenable  (byteenable),
            .writedata   (writedata),
            .waitrequest (wreq_v[g]),
            .readdata    (rdata_v[g]),
            .err         (err_v[g]),
            .xfer_count  (xfer_v[g])
        );
    end

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_m  [N][DEPTH];
    logic [7:0]  lfsr_m [N];
    bit          busy_m [N];
    int          wcnt_m [N];
    int          expw_m [N];
    bit          err_m  [N];
    logic [15:0] xcnt_m [N];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // next state of x^8+x^6+x^5+x^4+1: feedback is the parity of stages 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    // monitor: compares every completion against the queued expectation
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_v[i]) begin
                lfsr_m[i] = SEED;
                busy_m[i] = 1'b0;
                wcnt_m[i] = 0;
                err_m[i]  = 1'b0;
                xcnt_m[i] = 16'd0;
                chk("rst_waitrequest", 32'(wreq_v[i]), 32'(rd_v[i] | wr_v[i]));
                chk("rst_readdata", rdata_v[i], 32'h0);
            end
            chk("err_flag", 32'(err_v[i]), 32'(err_m[i]));
            chk("xfer_count", 32'(xfer_v[i]), 32'(xcnt_m[i]));
            if (rst_v[i] && (rd_v[i] || wr_v[i])) begin
                if (!busy_m[i]) begin
                    busy_m[i] = 1'b1;
                    wcnt_m[i] = 0;
                    expw_m[i] = int'(WC[i*4 +: 4]) + (SM[i] ? int'(lfsr_m[i][1:0]) : 0);
                end
                if (wreq_v[i]) begin
                    wcnt_m[i]++;
                    if (rd_v[i]) chk("readdata_while_wait", rdata_v[i], 32'h0);
                end else begin
                    exp_t e;
                    busy_m[i] = 1'b0;
                    chk("wait_cycles", 32'(wcnt_m[i]), 32'(expw_m[i]));
                    if (SM[i]) chk("stall_in_range", 32'(wcnt_m[i] <= 3), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: instance %0d with empty queue", i);
                    end else begin
                        e = exp_q.pop_front();
                        chk("completion_instance", 32'(i), 32'(e.inst));
                        if (e.is_rd) chk("readdata", rdata_v[i], e.data);
                        if (e.err) err_m[i] = 1'b1;
                    end
                    xcnt_m[i] = xcnt_m[i] + 16'd1;
                end
            end
            if (rst_v[i]) lfsr_m[i] = lfsr_step(lfsr_m[i]);
        end
    end

    task automatic issue(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] off;
        bit          inw;
        int          idx;
        off      = addr - BASE;
        inw      = off < 32'(DEPTH * 4);
        idx      = inw ? int'(off >> 2) : 0;
        e.inst   = i;
        e.is_rd  = rd;
        e.err    = !inw || (rd && wr);
        e.data   = (rd && inw) ? mem_m[i][idx] : 32'h0;
        if (wr && !rd && inw) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[i][idx][8*b +: 8] = wd[8*b +: 8];
        end
        exp_q.push_back(e);
        address    = addr;
        byteenable = be;
        writedata  = wd;
        rd_v[i]    = rd;
        wr_v[i]    = wr;
    endtask

    task automatic wait_done(input int i);
        int guard = 0;
        @(negedge clk);
        while (wreq_v[i] && guard < 60) begin
            guard++;
            @(negedge clk);
        end
        if (wreq_v[i]) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: instance %0d waitrequest still %b", i, wreq_v[i]);
        end
        @(posedge clk);
        #1;
        rd_v[i] = 1'b0;
        wr_v[i] = 1'b0;
    endtask

    task automatic xfer(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
        issue(i, rd, wr, addr, be, wd);
        wait_done(i);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++)
            for (int a = 0; a < DEPTH; a++) mem_m[i][a] = 32'h0;
        rst_v = '0; rd_v = '0; wr_v = '0;
        address = 32'h0; byteenable = 4'h0; writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_v = '1;
        @(negedge clk);
        chk("reset_waitrequest", 32'(wreq_v), 32'h0);
        chk("reset_xfer_count", 32'(xfer_v[2]), 32'h0);
        @(posedge clk);
        #1;

        // abort: reset mid-wait, master withdraws; no completion, no write
        address = BASE + 32'd16; byteenable = 4'hF; writedata = 32'h12345678;
        wr_v[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_v[2] = 1'b0;
        @(posedge clk);
        #1 rst_v[2] = 1'b1; wr_v[2] = 1'b0;
        xfer(2, 1, 0, BASE + 32'd16, 4'h0, 32'h0);

        // held write across a one-cycle reset restarts and completes W cycles after release
        issue(2, 0, 1, BASE + 32'd12, 4'hF, 32'h5A5AA5A5);
        repeat (2) @(posedge clk);
        #1 rst_v[2] = 1'b0;
        @(posedge clk);
        #1 rst_v[2] = 1'b1;
        @(negedge clk);
        chk("after_reset_err", 32'(err_v[2]), 32'h0);
        chk("after_reset_count", 32'(xfer_v[2]), 32'h0);
        wait_done(2);
        xfer(2, 1, 0, BASE + 32'd12, 4'h0, 32'h0);

        // fixed three-wait reads and writes
        xfer(1, 0, 1, BASE, 4'hF, 32'h3C021234);
        xfer(1, 1, 0, BASE, 4'h0, 32'h0);
        @(negedge clk);
        chk("idle_readdata", rdata_v[1], 32'h0);
        @(posedge clk);
        #1;
        xfer(1, 0, 1, BASE + 32'd4, 4'hF, 32'h11223344);
        xfer(1, 0, 1, BASE + 32'd4, 4'b0101, 32'hAABBCCDD);
        xfer(1, 1, 0, BASE + 32'd4, 4'h0, 32'h0);
        xfer(1, 0, 1, BASE + 32'd4, 4'h0, 32'hFFFFFFFF);
        xfer(1, 1, 0, BASE + 32'd4, 4'h0, 32'h0);
        xfer(1, 1, 0, BASE - 32'd4, 4'h0, 32'h0);
        xfer(1, 1, 1, BASE + 32'd4, 4'hF, 32'h00000000);
        xfer(1, 0, 1, OOW, 4'hF, 32'hFFFFFFFF);
        xfer(1, 1, 0, BASE, 4'h0, 32'h0);
        xfer(1, 1, 0, BASE + 32'd4, 4'h0, 32'h0);

        // stall mode: zero base wait plus LFSR-driven extra waits
        xfer(0, 0, 1, BASE + 32'd8, 4'hF, 32'hDEADBEEF);
        xfer(0, 1, 0, BASE + 32'd8, 4'h0, 32'h0);
        for (int k = 0; k < 100; k++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            xfer(0, 0, 1, a, 4'($urandom_range(0, 15)), $urandom);
            xfer(0, 1, 0, a, 4'h0, 32'h0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
